aud_cmd_tx: RTL

Host-to-target AUD command transmitter. Pops 32-bit command words from the AUD core's command FIFO and serialises them, least-significant nibble first, onto the AUD nibble bus (AUDCK/AUDSYNC/AUDATA) for RAM-monitor access. It is the outbound counterpart to the capture path and sits between the command FIFO's read side and the pad drivers.

---
 rtl/aud_cmd_tx_if.sv | 28 ++
 rtl/aud_cmd_tx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/aud_cmd_tx_if.sv
// aud_cmd_tx_if: groups the command-FIFO read side and the AUD nibble bus
// of the AUD command transmitter. The slave modport is the transmitter;
// the master modport is the FIFO/pad side that feeds and observes it.

interface aud_cmd_tx_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 4
);
   logic                   en_i;
   logic [DATA_WIDTH-1:0]  fifo_dat_i;
   logic [ADDRESS_WIDTH:0] fifo_count_i;
   logic                   fifo_re_o;
   logic                   aud_ck_o;
   logic                   aud_sync_o;
   logic [3:0]             aud_data_o;
   logic                   aud_oe_o;
   logic                   busy_o;

   modport master (
      output en_i, fifo_dat_i, fifo_count_i,
      input  fifo_re_o, aud_ck_o, aud_sync_o, aud_data_o, aud_oe_o, busy_o
   );

   modport slave (
      input  en_i, fifo_dat_i, fifo_count_i,
      output fifo_re_o, aud_ck_o, aud_sync_o, aud_data_o, aud_oe_o, busy_o
   );
endinterface

// File: rtl/aud_cmd_tx.sv
// aud_cmd_tx: AUD host-to-target command transmitter.
// Pops 32-bit command words from the command FIFO and shifts them out,
// least-significant nibble first, on AUDCK/AUDSYNC/AUDATA. All bus outputs
// change only on AUDCK falling edges so the target samples on the rising edge.
// Optional feature: define AUD_TX_PARITY_EN to append an XOR parity nibble
// after the data nibbles.

module aud_cmd_tx #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 4,
   parameter int CLK_DIV       = 2,
   parameter int GAP_CK        = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   aud_cmd_tx_if.slave bus
);

`ifdef AUD_TX_PARITY_EN
   localparam int NIB_N = DATA_WIDTH / 4 + 1;
`else
   localparam int NIB_N = DATA_WIDTH / 4;
`endif
   localparam int SH_W  = NIB_N * 4;
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int NIB_W = $clog2(NIB_N + 1);
   localparam int GAP_W = $clog2(GAP_CK + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

`ifdef AUD_TX_PARITY_EN
   // XOR of all data nibbles; sent as the final nibble of the frame.
   function automatic logic [3:0] parity_nib(input logic [DATA_WIDTH-1:0] word);
      logic [3:0] acc;
      acc = 4'd0;
      for (int i = 0; i < DATA_WIDTH / 4; i++) begin
         acc = acc ^ word[i*4 +: 4];
      end
      return acc;
   endfunction
`endif

   state_t            state_r, state_s;
   logic [DIV_W-1:0]  div_cnt_r;
   logic              aud_ck_r;
   logic              div_last_s;
   logic              fall_tick_s;
   logic              start_s;
   logic [SH_W-1:0]   load_word_s;
   logic [SH_W-1:0]   shift_r, shift_s;
   logic [NIB_W-1:0]  nib_cnt_r, nib_cnt_s;
   logic [GAP_W-1:0]  gap_cnt_r, gap_cnt_s;
   logic              fifo_re_r, fifo_re_s;
   logic              sync_r, sync_s;
   logic [3:0]        data_r, data_s;
   logic              oe_r, oe_s;
   logic              busy_r, busy_s;

   // The parity nibble (when compiled in) rides above the data so a plain
   // right shift walks through the whole frame.
`ifdef AUD_TX_PARITY_EN
   assign load_word_s = {parity_nib(bus.fifo_dat_i), bus.fifo_dat_i};
`else
   assign load_word_s = bus.fifo_dat_i;
`endif

   assign start_s     = bus.en_i && (bus.fifo_count_i != {(ADDRESS_WIDTH + 1){1'b0}});
   assign div_last_s  = (div_cnt_r == DIV_W'(CLK_DIV - 1));
   assign fall_tick_s = div_last_s && aud_ck_r;

   // Free-running AUDCK divider: toggles the clock every CLK_DIV cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_r <= {DIV_W{1'b0}};
         aud_ck_r  <= 1'b0;
      end else if (div_last_s) begin
         div_cnt_r <= {DIV_W{1'b0}};
         aud_ck_r  <= ~aud_ck_r;
      end else begin
         div_cnt_r <= div_cnt_r + DIV_W'(1);
      end
   end

   // State and registered bus outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         shift_r   <= {SH_W{1'b0}};
         nib_cnt_r <= {NIB_W{1'b0}};
         gap_cnt_r <= {GAP_W{1'b0}};
         fifo_re_r <= 1'b0;
         sync_r    <= 1'b1;
         data_r    <= 4'd0;
         oe_r      <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         shift_r   <= shift_s;
         nib_cnt_r <= nib_cnt_s;
         gap_cnt_r <= gap_cnt_s;
         fifo_re_r <= fifo_re_s;
         sync_r    <= sync_s;
         data_r    <= data_s;
         oe_r      <= oe_s;
         busy_r    <= busy_s;
      end
   end

   // Next-state and next-output decode; a frame launched straight out of GAP
   // drives nibble 0 on the exit fall tick so the inter-frame idle is exactly
   // GAP_CK AUDCK periods.
   always_comb begin
      state_s   = state_r;
      shift_s   = shift_r;
      nib_cnt_s = nib_cnt_r;
      gap_cnt_s = gap_cnt_r;
      fifo_re_s = 1'b0;
      sync_s    = sync_r;
      data_s    = data_r;
      oe_s      = oe_r;
      case (state_r)
         ST_IDLE: begin
            sync_s = 1'b1;
            data_s = 4'd0;
            oe_s   = 1'b0;
            if (start_s) begin
               shift_s   = load_word_s;
               fifo_re_s = 1'b1;
               state_s   = ST_LOAD;
            end else begin
               state_s   = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (fall_tick_s) begin
               data_s    = shift_r[3:0];
               shift_s   = shift_r >> 3'd4;
               sync_s    = 1'b0;
               oe_s      = 1'b1;
               nib_cnt_s = {NIB_W{1'b0}};
               state_s   = ST_SHIFT;
            end else begin
               state_s   = ST_LOAD;
            end
         end
         ST_SHIFT: begin
            if (fall_tick_s) begin
               if (nib_cnt_r == NIB_W'(NIB_N - 1)) begin
                  sync_s    = 1'b1;
                  data_s    = 4'd0;
                  oe_s      = 1'b0;
                  gap_cnt_s = GAP_W'(GAP_CK);
                  state_s   = ST_GAP;
               end else begin
                  data_s    = shift_r[3:0];
                  shift_s   = shift_r >> 3'd4;
                  nib_cnt_s = nib_cnt_r + NIB_W'(1);
               end
            end else begin
               state_s = ST_SHIFT;
            end
         end
         ST_GAP: begin
            if (fall_tick_s) begin
               if (gap_cnt_r == GAP_W'(1)) begin
                  if (start_s) begin
                     data_s    = load_word_s[3:0];
                     shift_s   = load_word_s >> 3'd4;
                     sync_s    = 1'b0;
                     oe_s      = 1'b1;
                     nib_cnt_s = {NIB_W{1'b0}};
                     fifo_re_s = 1'b1;
                     state_s   = ST_SHIFT;
                  end else begin
                     state_s   = ST_IDLE;
                  end
               end else begin
                  gap_cnt_s = gap_cnt_r - GAP_W'(1);
               end
            end else begin
               state_s = ST_GAP;
            end
         end
         default: begin
            sync_s  = 1'b1;
            data_s  = 4'd0;
            oe_s    = 1'b0;
            state_s = ST_IDLE;
         end
      endcase
      busy_s = (state_s != ST_IDLE);
   end

   assign bus.fifo_re_o  = fifo_re_r;
   assign bus.aud_ck_o   = aud_ck_r;
   assign bus.aud_sync_o = sync_r;
   assign bus.aud_data_o = data_r;
   assign bus.aud_oe_o   = oe_r;
   assign bus.busy_o     = busy_r;

endmodule
